// File: rtl/flatten_buffer.sv
// rtl/flatten_buffer.sv - collects a serial element stream into a held flattened vector
module flatten_buffer #(
    parameter int FLATTENED_LENGTH = 432,
    parameter int DATA_WIDTH       = 8,
    parameter int COUNT_WIDTH      = $clog2(FLATTENED_LENGTH + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH-1:0]                        in_data,
    input  logic                                         in_last,
    input  logic                                         fc_done,
    output logic [FLATTENED_LENGTH-1:0][DATA_WIDTH-1:0]  flattened_outfmap,
    output logic                                         fullyconnect_start,
    output logic [COUNT_WIDTH-1:0]                       fill_count,
    output logic                                         frame_error
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    logic   transfer;
    logic   at_last_index;

    assign in_ready           = (state == FILL);
    assign fullyconnect_start = (state == HOLD);
    assign transfer           = in_valid && in_ready;
    assign at_last_index      = (fill_count == COUNT_WIDTH'(FLATTENED_LENGTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= FILL;
            fill_count        <= '0;
            frame_error       <= 1'b0;
            flattened_outfmap <= '0;
        end else begin
            frame_error <= 1'b0;
            // Flush aborts the frame without touching stored data or flagging an error.
            if (flush) begin
                state      <= FILL;
                fill_count <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (transfer) begin
                            for (int i = 0; i < FLATTENED_LENGTH; i++) begin
                                if (fill_count == COUNT_WIDTH'(i)) begin
                                    flattened_outfmap[i] <= in_data;
                                end
                            end
                            if (at_last_index && in_last) begin
                                state      <= HOLD;
                                fill_count <= COUNT_WIDTH'(FLATTENED_LENGTH);
                            end else if (at_last_index || in_last) begin
                                // Early or missing last marker: drop the frame, restart at index 0.
                                fill_count  <= '0;
                                frame_error <= 1'b1;
                            end else begin
                                fill_count <= fill_count + COUNT_WIDTH'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (fc_done) begin
                            state      <= FILL;
                            fill_count <= '0;
                        end
                    end
                    default: begin
                        state      <= FILL;
                        fill_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/flatten_buffer.md
# flatten_buffer

Collects the serial stream of pooled feature-map values into the flattened vector consumed by the fully connected stage. Holds that vector stable and raises `fullyconnect_start` until the fully connected stage signals completion. Sits between the pooling stage (upstream, valid/ready stream) and the fully connected stage (downstream, parallel array plus start level). One frame is one complete flattened vector.

## Interface

Parameters:
- `FLATTENED_LENGTH`, 432, number of elements per frame; must be ≥ 2; overwritten by the CNN top.
- `DATA_WIDTH`, 8, element width (unsigned); overwritten by the CNN top.
- `COUNT_WIDTH`, `$clog2(FLATTENED_LENGTH+1)`, width of `fill_count`; derived, never overridden.

Ports:
- `clk`, in, 1, single clock; all state changes on its rising edge.
- `rst_n`, in, 1, reset, asynchronous and active-low.
- `flush`, in, 1, synchronous frame abort.
- `in_valid`, in, 1, upstream element valid.
- `in_ready`, out, 1, block accepts an element this cycle.
- `in_data`, in, DATA_WIDTH, unsigned element.
- `in_last`, in, 1, marks the final element of a frame.
- `fc_done`, in, 1, fully connected stage has consumed the vector.
- `flattened_outfmap`, out, DATA_WIDTH × [FLATTENED_LENGTH], registered vector.
- `fullyconnect_start`, out, 1, vector complete and stable.
- `fill_count`, out, COUNT_WIDTH, number of elements accepted in the current frame.
- `frame_error`, out, 1, one-cycle pulse when a malformed frame is discarded.

## Operation

- The block has two states:
  - FILL: `in_ready` = 1.
  - HOLD: `in_ready` = 0 and `fullyconnect_start` = 1.
- `in_ready` is decoded combinationally from the state only. It never depends on `in_valid`.
- Transfer rule: a transfer occurs when `in_valid` && `in_ready`. In that case, `in_data` is written to `flattened_outfmap[fill_count]` and `fill_count` increments.
- Element order is the arrival order. Index 0 is the first transfer of the frame.
- Completion: a transfer at index FLATTENED_LENGTH-1 with `in_last`=1 moves the block to HOLD, and `fill_count` = FLATTENED_LENGTH.
- Malformed frame, case 1: `in_last`=1 on a transfer at index < FLATTENED_LENGTH-1.
- Malformed frame, case 2: `in_last`=0 on the transfer at index FLATTENED_LENGTH-1.
- Response to either malformed case:
  - The element is still written.
  - `fill_count` goes to 0.
  - The state stays FILL.
  - `frame_error` pulses for 1 cycle.
  - The next transfer starts a new frame at index 0.
- In HOLD:
  - The vector and `fill_count` are frozen.
  - `in_valid` is ignored; there is no write.
  - On `fc_done`=1: the block moves to FILL and `fill_count` goes to 0.
- `fc_done` in FILL is ignored.
- `flush`=1 has priority over everything:
  - State goes to FILL and `fill_count` to 0.
  - The vector is not cleared.
  - No write happens that cycle, even if `in_valid`=1.
  - `frame_error` is not pulsed.
- The vector is never cleared except by reset. Each new frame overwrites every element before HOLD is reached.

## Timing

- Reset values:
  - state FILL
  - `in_ready` 1
  - `fill_count` 0
  - every `flattened_outfmap` element 0
  - `fullyconnect_start` 0
  - `frame_error` 0
- Reset asserted mid-frame or mid-HOLD returns all of the above values immediately (asynchronous). There is no pending state.
- Throughput is 1 element/cycle in FILL. A frame needs ≥ FLATTENED_LENGTH cycles.
- Completion timing, with the final transfer on edge N:
  - After edge N: `fullyconnect_start`=1 and `in_ready`=0.
  - The vector is fully valid in the same cycle that start is first high.
- `fc_done` sampled high on edge M: after edge M, `fullyconnect_start`=0, `in_ready`=1 and `fill_count`=0.
- Minimum HOLD duration is 1 cycle, when `fc_done` is already high on the first HOLD edge.
- `frame_error` is registered. It is high only in the cycle after the offending transfer edge.
- `fc_done` and `flush` on the same edge: the flush outcome applies. The two outcomes are identical.

## Test plan

Directed scenarios use FLATTENED_LENGTH=8 and DATA_WIDTH=8.

1. Reset, then stream 1..8 with `in_last` on the 8th element.
   - Vector must read {1,...,8}.
   - `fullyconnect_start` must rise 1 cycle after the 8th transfer.
   - `fill_count`=8 and `in_ready`=0.
2. In HOLD, drive `in_valid`=1 with data 0xFF for 5 cycles, then pulse `fc_done`.
   - Vector must be unchanged.
   - Start must drop the next cycle, with `fill_count`=0 and `in_ready`=1.
3. Stream 8 elements with `in_valid` toggling every cycle (random gaps).
   - Exactly 8 transfers must be recorded in order.
   - Start must rise only after the 8th transfer.
4. Send `in_last` on element index 4, then send a correct frame 11..18.
   - `frame_error` must pulse once and `fill_count` must return to 0.
   - Vector must end as {11,...,18} and start must rise.
5. Send 8 elements without `in_last`.
   - `frame_error` must pulse and there must be no HOLD.
   - Then, mid-frame at `fill_count`=5, assert `flush` together with `in_valid`: `fill_count` must go to 0 with no write and no error pulse.
6. Assert `rst_n`=0 asynchronously mid-HOLD (between clock edges).
   - Start must drop to 0 immediately.
   - Vector must read all 0 and `in_ready` must be 1 after release.
